// File: rtl/madd_sched_pkg.sv
// Shared types and helpers for the madd sharing scheduler.
// Latency: n/a (declarations and a combinational function only).
// Backpressure: n/a.
// Contents: FSM state enum, operand field layout, exact multiply-add reference.
package madd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  // Operand word: a = [1:0], b = [3:2], c = [5:4]
  localparam int OPA_LSB = 0;
  localparam int OPB_LSB = 2;
  localparam int OPC_LSB = 4;
  localparam int OPND_W  = 6;
  localparam int RES_W   = 4;

  // Exact a*b+c; the 5-bit width keeps headroom above the nominal 0..12 range.
  function automatic logic [4:0] exact_madd(input logic [OPND_W-1:0] opnd);
    logic [4:0] a, b, c;
    a = {3'b000, opnd[OPA_LSB +: 2]};
    b = {3'b000, opnd[OPB_LSB +: 2]};
    c = {3'b000, opnd[OPC_LSB +: 2]};
    exact_madd = a * b + c;
  endfunction

endpackage

// File: rtl/madd_rr_arb.sv
// Round-robin picker: first valid requester scanning upward from last_grant+1.
// Latency: purely combinational, 0 cycles.
// Backpressure: enable_i low forces an all-zero grant.
// Ports: req_i (request vector), last_grant_i, enable_i -> grant_o (one-hot), grant_idx_o.
module madd_rr_arb #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_grant_i,
  input  logic            enable_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   grant_idx_o
);

  int          cand_int;
  logic [IW-1:0] cand;
  logic        found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand_int    = 0;
    cand        = '0;
    // Offset NREQ wraps back to last_grant itself, so it is considered last.
    for (int k = 1; k <= NREQ; k++) begin
      cand_int = (int'(last_grant_i) + k) % NREQ;
      cand     = IW'(cand_int);
      if (enable_i && !found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/madd_share_sched.sv
// Round-robin scheduler sharing one external combinational multiply-add unit among NREQ requesters.
// Latency: grant to rsp_valid is 2 cycles; one operation per 2 cycles with rsp_ready held high.
// Backpressure: while rsp_ready is low the response holds and no requester is granted.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_opnd (per-requester operands);
//        madd_in/madd_out (external madd unit); rsp_valid/rsp_ready/rsp_id/rsp_data (response).
// Optional: define MADD_ERR_CHECK_EN to add err_flag, err_cnt and max_err error tracking vs. threshold ET.
module madd_share_sched
  import madd_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ET   = 8,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [OPND_W*NREQ-1:0]   req_opnd,
  output logic [OPND_W-1:0]        madd_in,
  input  logic [RES_W-1:0]         madd_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IW-1:0]            rsp_id,
  output logic [RES_W-1:0]         rsp_data
`ifdef MADD_ERR_CHECK_EN
  ,
  output logic                     err_flag,
  output logic [15:0]              err_cnt,
  output logic [RES_W-1:0]         max_err
`endif
);

  state_e              state_q;
  logic [IW-1:0]       last_grant_q;
  logic [OPND_W-1:0]   opnd_q;
  logic [IW-1:0]       id_q;
  logic                rsp_valid_q;
  logic [IW-1:0]       rsp_id_q;
  logic [RES_W-1:0]    rsp_data_q;

  logic                win;
  logic [NREQ-1:0]     gnt;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;
  logic [OPND_W-1:0]   opnd_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_opnd
    assign opnd_arr[g] = req_opnd[g*OPND_W +: OPND_W];
  end

  // A new operation may start when idle, or when the current response retires this cycle.
  assign win = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);

  madd_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .enable_i     (win),
    .grant_o      (gnt),
    .grant_idx_o  (gnt_idx)
  );

  assign gnt_any   = |gnt;
  assign req_ready = gnt;

  // opnd_q doubles as the madd_in register: loaded only on grant, so the
  // external unit sees no toggling outside an operation.
  assign madd_in   = opnd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef MADD_ERR_CHECK_EN
  logic             err_flag_q;
  logic [15:0]      err_cnt_q;
  logic [RES_W-1:0] max_err_q;
  logic [4:0]       exact_w;
  logic [4:0]       diff_w;
  logic [RES_W-1:0] diff_sat;
  logic             err_hit;

  always_comb begin
    exact_w  = exact_madd(opnd_q);
    diff_w   = (exact_w >= {1'b0, madd_out}) ? (exact_w - {1'b0, madd_out})
                                             : ({1'b0, madd_out} - exact_w);
    diff_sat = (diff_w > 5'd15) ? 4'hF : diff_w[3:0];
    err_hit  = (diff_w > 5'(ET));
  end

  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;
  assign max_err  = max_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NREQ - 1);
      opnd_q       <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
`ifdef MADD_ERR_CHECK_EN
      err_flag_q   <= 1'b0;
      err_cnt_q    <= '0;
      max_err_q    <= '0;
`endif
    end else begin
      // Grants only occur inside the window, so the capture is state-agnostic.
      if (gnt_any) begin
        opnd_q       <= opnd_arr[gnt_idx];
        id_q         <= gnt_idx;
        last_grant_q <= gnt_idx;
      end
      case (state_q)
        IDLE: begin
          if (gnt_any) state_q <= EVAL;
        end
        EVAL: begin
          rsp_data_q  <= madd_out;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
`ifdef MADD_ERR_CHECK_EN
          err_flag_q <= err_hit;
          if (err_hit && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
          if (diff_sat > max_err_q) max_err_q <= diff_sat;
`endif
        end
        RESP: begin
          // A retired response is never re-presented, even when a
          // back-to-back grant sends us straight into EVAL.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= gnt_any ? EVAL : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/madd_share_sched.md
Name: madd_share_sched

Overview:
- Round-robin scheduler that shares one combinational 6-in/4-out multiply-add unit (approximate or exact) between NREQ requesters.
- The madd unit sits outside this block and is driven through the madd_in/madd_out ports, so any synthesized approximate variant can be swapped in without changing the scheduler.
- Operand word layout: a = opnd[1:0], b = opnd[3:2], c = opnd[5:4]. Nominal result is a*b+c, range 0..12, 4 bits.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ET, 8, error threshold used by the optional error checker (0..15).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  one-hot grant; a transfer occurs on valid & ready.
- req_opnd  in  6*NREQ  operand word of requester i at bits [6i+5:6i].
- madd_in  out  6  operands to the external madd unit; driven from a register.
- madd_out  in  4  result from the external madd unit (combinational from madd_in).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the response.
- rsp_data  out  4  captured madd result.

Behaviour:
- States: IDLE, EVAL, RESP.
- Reset values:
  - state = IDLE; all req_ready = 0; rsp_valid = 0; rsp_id = 0; rsp_data = 0; madd_in = 0.
  - last_grant = NREQ-1, so requester 0 has first priority.
  - Reset mid-operation discards any in-flight operation and pending response; no partial transfer completes.
- Grant window:
  - Open in IDLE, or in RESP in the same cycle that rsp_ready = 1.
  - Grant goes to the first requester with req_valid = 1, scanning upward from (last_grant+1) mod NREQ with wrap-around.
  - req_ready is combinational, one-hot, and asserted only for the chosen requester; all zero outside the grant window or when no requester is valid.
- On a grant:
  - opnd_q <= req_opnd slice of the granted requester; id_q <= its index; last_grant <= its index.
  - Next state = EVAL.
- EVAL (exactly 1 cycle):
  - madd_in = opnd_q.
  - rsp_data <= madd_out; rsp_id <= id_q; rsp_valid <= 1.
  - Next state = RESP.
- RESP:
  - Outputs held stable while rsp_ready = 0, regardless of req_valid activity.
  - On rsp_ready = 1: response retires. If a grant happens in the same cycle, next state = EVAL; otherwise rsp_valid <= 0 and next state = IDLE.
- Latency and throughput:
  - Grant to rsp_valid is 2 cycles.
  - Sustained throughput is one operation per 2 cycles when rsp_ready is held at 1.
- A requester that deasserts req_valid without receiving req_ready is simply skipped; no state is kept per requester.
- madd_in keeps its last value outside EVAL, which avoids needless toggling in the external unit.

Optional Feature:
- Macro: MADD_ERR_CHECK_EN.
- Defined:
  - Adds outputs err_flag (1 bit), err_cnt (16 bits) and max_err (4 bits).
  - In EVAL: exact = a*b+c, computed internally at 5 bits; diff = |exact - madd_out|.
  - err_flag <= (diff > ET) and is registered alongside rsp_data.
  - err_cnt increments by 1 for every EVAL with diff > ET and saturates at 0xFFFF.
  - max_err <= max(max_err, diff), saturating at 15.
  - All three outputs reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package madd_sched_pkg holds:
  - state enum {IDLE, EVAL, RESP};
  - operand field constants OPA_LSB = 0, OPB_LSB = 2, OPC_LSB = 4, OPND_W = 6, RES_W = 4;
  - function exact_madd(opnd), returning 5 bits.
- One sub-module: madd_rr_arb (parameter NREQ).
  - Inputs: req vector, last_grant, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; the last_grant register stays in the parent.

Test Plan:
- Bench drives madd_out = exact a*b+c.
  - Stimulus: after reset, requester 0 presents opnd 6'b01_11_10 (c=1, b=3, a=2).
  - Required: req_ready[0] = 1 in cycle 0; madd_in = 6'b011110 in cycle 1; rsp_valid = 1, rsp_data = 7, rsp_id = 0 in cycle 2.
- Stimulus: all 4 requesters valid continuously, rsp_ready = 1.
  - Required: grants in order 0, 1, 2, 3, 0, ...; a new rsp_valid pulse every 2 cycles; no grant lost or duplicated.
- Stimulus: rsp_ready = 0 for 5 cycles while requesters 1 and 2 are valid.
  - Required: rsp_data and rsp_id stable throughout; req_ready = 0 throughout; requester 1 is granted in the cycle rsp_ready rises.
- Stimulus: rst asserted during EVAL.
  - Required: next cycle rsp_valid = 0, state = IDLE, and requester 0 again has priority.
- Stimulus (MADD_ERR_CHECK_EN, ET = 8): bench forces madd_out = 0 with opnd a=3, b=3, c=3 (exact 12).
  - Required: err_flag = 1, err_cnt = 1, max_err = 12.
  - Then opnd a=1, b=1, c=0 with madd_out = 0 gives diff = 1: err_flag = 0, err_cnt stays 1, max_err stays 12.
- Stimulus: preload err_cnt = 0xFFFF, then one more violation.
  - Required: err_cnt stays at 0xFFFF.
